// File: rtl/seq_arith_pkg.sv
// Shared definitions for the sequential arithmetic units (multiplier and divider).
// Latency: n/a (types, encodings and helper functions only).
// Backpressure: n/a.
package seq_arith_pkg;

  // Control state encoding, shared with the restoring divider so one master drives both.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  // Width of an iteration counter that must hold values 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage : seq_arith_pkg

// File: rtl/seq_mul.sv
// Iterative shift-add unsigned multiplier, N x N -> 2N bits, one multiplier bit per clock.
// Latency: exactly N cycles from the edge that samples sen2 (while armed) to done/P valid.
// Backpressure: none; sen1 arms, sen2 starts, done is a level held until the next arm.
module seq_mul
  import seq_arith_pkg::*;
#(
  parameter  int N     = 20,
  localparam int CNT_W = cnt_width(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  input  logic           sen1,
  input  logic           sen2,
  output logic [2*N-1:0] P,
  output logic           busy,
  output logic           done
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  state_e           state_q, state_d;
  logic [N-1:0]     a_q, a_d;
  logic [N-1:0]     b_q, b_d;
  logic [N-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*N-1:0]   p_q, p_d;
  logic             done_q, done_d;

  // acc_hi + (B[0] ? A : 0) kept at N+1 bits; the carry becomes the top bit after the shift.
  logic [N:0]       sum;

  // Next-state and datapath update: arm in IDLE, track operands in LOAD, add/shift in RUN.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    done_d  = done_q;
    sum     = {1'b0, acc_q} + (b_q[0] ? {1'b0, a_q} : {(N + 1){1'b0}});

    unique case (state_q)
      IDLE: begin
        // sen2 is deliberately ignored here; starting always requires a LOAD pass first.
        if (sen1) begin
          state_d = LOAD;
          done_d  = 1'b0;
        end
      end

      LOAD: begin
        // Operands are resampled every cycle so the values present on the start edge win.
        a_d   = multiplicand;
        b_d   = multiplier;
        acc_d = '0;
        cnt_d = '0;
        if (sen2) begin
          state_d = RUN;
        end
      end

      RUN: begin
        // Shift {carry, acc, B} right by one: the low sum bit drops into the B half,
        // which also retires the multiplier bit just consumed.
        acc_d = sum[N:1];
        b_d   = {sum[0], b_q[N-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          p_d     = {acc_d, b_d};
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Register all state; synchronous reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      done_q  <= done_d;
    end
  end

  assign P    = p_q;
  assign done = done_q;
  assign busy = (state_q == RUN);

endmodule : seq_mul

// File: tb/tb_seq_mul.sv
// Scoreboard bench for seq_mul: stimulus pushes expected products, a monitor checks on done.
// Latency: checks done arrives exactly N cycles after the start edge, busy high for N cycles.
// Backpressure: n/a (bench drives sen1/sen2 like a master and deasserts on start).
module tb_seq_mul;

  localparam int N = 20;

  logic           clk;
  logic           reset;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic           sen1;
  logic           sen2;
  logic [2*N-1:0] P;
  logic           busy;
  logic           done;

  int errors = 0;
  int checks = 0;

  logic [2*N-1:0] exp_q[$];
  logic           done_prev;

  seq_mul #(.N(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .sen1         (sen1),
    .sen2         (sen2),
    .P            (P),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: every rising edge of done must present the next expected product.
  initial begin
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done === 1'b1 && done_prev !== 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'(P), 64'hDEAD);
        end else begin
          check("product", 64'(P), 64'(exp_q.pop_front()));
        end
      end
      done_prev = done;
    end
  end

  // One arm/start transaction. dly = cycles spent in LOAD before sen2; same = raise both in IDLE.
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2*N-1:0] exp,
                       input int dly, input bit same);
    int cyc;
    int busy_cnt;
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    sen1         = 1'b1;
    sen2         = same;
    exp_q.push_back(exp);
    @(negedge clk);                 // arm edge has passed: LOAD
    check("arm_done_clear", 64'(done), 64'd0);
    check("arm_not_busy", 64'(busy), 64'd0);
    if (!same) begin
      repeat (dly) @(negedge clk);
      sen2 = 1'b1;
    end
    @(negedge clk);                 // start edge k has passed: RUN
    sen1 = 1'b0;
    sen2 = 1'b0;
    multiplicand = ~a;              // must be ignored while running
    multiplier   = b ^ 20'h5A5A5;
    cyc      = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && cyc < N + 5) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    check("done_latency", 64'(cyc), 64'(N));
    check("busy_cycles", 64'(busy_cnt), 64'(N));
    check("busy_low_at_done", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [N-1:0] ra, rb;
    reset        = 1'b1;
    sen1         = 1'b0;
    sen2         = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_P", 64'(P), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    reset = 1'b0;

    do_op(20'd25, 20'd3, 40'd75, 0, 1'b0);
    do_op(20'd14400, 20'd480, 40'd6912000, 2, 1'b0);

    // done and P hold while nobody re-arms
    repeat (3) @(negedge clk);
    check("done_hold", 64'(done), 64'd1);
    check("P_hold", 64'(P), 64'd6912000);

    do_op(20'hFFFFF, 20'hFFFFF, 40'hFFFFE00001, 1, 1'b0);

    // Reset in the middle of RUN: abandons the operation, clears everything.
    @(negedge clk);
    multiplicand = 20'd14400;
    multiplier   = 20'd480;
    sen1         = 1'b1;
    @(negedge clk);
    sen2 = 1'b1;
    @(negedge clk);
    sen1 = 1'b0;
    sen2 = 1'b0;
    repeat (7) @(negedge clk);
    check("busy_before_reset", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("midrun_reset_P", 64'(P), 64'd0);
    check("midrun_reset_done", 64'(done), 64'd0);
    check("midrun_reset_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    repeat (N + 3) @(negedge clk);
    check("no_done_after_abort", 64'(done), 64'd0);

    do_op(20'd25, 20'd3, 40'd75, 0, 1'b0);
    do_op(20'd0, 20'd12345, 40'd0, 3, 1'b0);
    // simultaneous sen1/sen2 in IDLE goes through LOAD; operands scrambled during RUN
    do_op(20'd1000, 20'd999, 40'd999000, 0, 1'b1);
    do_op(20'd1, 20'hFFFFF, 40'h00000FFFFF, 5, 1'b0);
    do_op(20'h80000, 20'd2, 40'h0000100000, 4, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      ra = N'($urandom());
      rb = N'($urandom());
      do_op(ra, rb, (2*N)'(ra) * (2*N)'(rb), int'($urandom_range(0, 5)), 1'b0);
    end

    @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_seq_mul

// File: doc/seq_mul.md
Name: seq_mul

Overview:
- Iterative shift-add unsigned multiplier; the inverse-direction partner of the team's sequential restoring divider.
- Multiplies an N-bit multiplicand by an N-bit multiplier, one partial-product bit per clock, giving a full 2N-bit product.
- Uses the same two-step sen1/sen2 arm/start handshake and level done flag as the divider, so control logic drives either unit identically.
- Sits in the datapath beside the divider, e.g. to rescale quotients (value * constant).

Parameters:
- N, 20, operand width in bits; N >= 2.
- CNT_W, $clog2(N), iteration counter width (derived; not overridden).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset; takes effect on the rising clk edge where it is sampled high.
- multiplicand  input  N  operand A, unsigned.
- multiplier  input  N  operand B, unsigned.
- sen1  input  1  arm request, level; latches operands.
- sen2  input  1  start request, level; sampled only while armed.
- P  output  2N  product A*B, registered.
- busy  output  1  high while iterating (state RUN).
- done  output  1  level flag: result in P is valid.

Behaviour:
- Reset (synchronous, high): state=IDLE, P=0, done=0, busy=0, internal accumulator/operand registers=0, count=0. Reset overrides everything, including mid-RUN; the operation is abandoned and no done is produced.
- States: IDLE, LOAD, RUN (2-bit encoding from the shared package).
- IDLE: if sen1=1, go to LOAD and clear done. sen2 is ignored in IDLE, even when high simultaneously with sen1. P holds its last value.
- LOAD: every cycle, latch A<=multiplicand, B<=multiplier, acc<=0, count<=0. If sen2=1, go to RUN; the operands latched on that same edge are the ones used. If sen1 drops while sen2=0, stay in LOAD (no abort).
- RUN, one iteration per cycle:
  - if B[0], acc_hi += A, computed as N+1 bits with the carry kept;
  - then shift {carry, acc, B} right by 1.
  - count increments each cycle.
  - When count==N-1, that edge writes P <= final {acc, B} (2N bits), sets done=1 and busy=0, clears count, and goes to IDLE.
- Latency: the sen2-sampling edge is edge k. busy is high after edges k..k+N-1. done=1 and P valid after edge k+N, i.e. exactly N cycles, independent of operand values (no zero early-out).
- done stays 1 until the next arm (IDLE with sen1=1). P is stable from done until the next completion; it is not cleared by arming.
- sen1/sen2/operand changes during RUN have no effect.
- If sen1 and sen2 are still high when the block returns to IDLE, it re-arms on the next edge (done clears) and starts again one edge later. Masters deassert both on seeing done.
- Arithmetic: fully unsigned, product width 2N, no overflow possible. Carry out of the acc_hi addition is retained in bit N+1 of the shift path and must never be lost.

Decomposition:
- Package seq_arith_pkg holds:
  - state localparams IDLE/LOAD/RUN (shared with the divider's encoding style);
  - a helper function for the counter width.
- No sub-module: the add/shift datapath and FSM are small and live in one module, in two always blocks (next-state combinational, registered datapath).

Test Plan:
- Reset, then A=25, B=3, sen1 at edge 1, sen2 at edge 2 -> done=1 exactly N=20 cycles after the sen2 edge, P=75, busy high for those 20 cycles.
- A=14400, B=480 -> P=6912000; done held high until sen1 is reasserted, then drops the cycle after the arm.
- A=B=2^20-1 -> P=0xFFFFE00001 (carry path check); A=0, B=12345 -> P=0 still after 20 cycles.
- Assert reset at RUN cycle 7 -> next cycle state IDLE, P=0, done=0, busy=0; a fresh 25*3 then completes correctly.
- sen1 and sen2 raised in the same IDLE cycle -> LOAD first, RUN one edge later; change operands during RUN -> P reflects the values latched at the sen2 edge.
- Random regression: 1000 random A,B pairs compared against an A*B reference model, with random sen2 delays of 0-5 cycles in LOAD.
